// File: rtl/mcif_rr_arb_seq.sv
// Registered round-robin arbiter: grant is held for a whole multi-beat transaction, 1-cycle request-to-grant latency.
// Backpressure: arb_ack_i stalls the beat counter only; handover on the last accepted beat is back-to-back.
module mcif_rr_arb_seq #(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               arb_en_i,
  input  logic [NUM_REQ-1:0] arb_req_i,
  input  logic [NUM_REQ-1:0] arb_last_i,
  input  logic               arb_ack_i,
  output logic               arb_gnt_vld_o,
  output logic [NUM_REQ-1:0] arb_gnt_o,
  output logic [ID_W-1:0]    arb_gnt_id_o,
  output logic [CNT_W-1:0]   arb_beat_cnt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [ID_W-1:0]    RST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req_g;
  logic               last_g;
  logic [NUM_REQ-1:0] rest_mask;
  logic [ID_W-1:0]    win_id;

  // First set bit in mask searching ptr+1, ptr+2, ... wrapping, ending at ptr.
  function automatic logic [ID_W-1:0] pick(input logic [ID_W-1:0] ptr,
                                           input logic [NUM_REQ-1:0] mask);
    logic [ID_W-1:0] res;
    logic            found;
    int              idx;
    res   = ptr;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && mask[idx]) begin
        res   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // gnt_q is one-hot on the owner while granted, so it doubles as the owner select.
  assign req_g     = |(arb_req_i & gnt_q);
  assign last_g    = |(arb_last_i & gnt_q);
  assign rest_mask = arb_req_i & ~gnt_q;

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    gnt_vld_d = gnt_vld_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    win_id    = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en_i && (|arb_req_i)) begin
          win_id    = pick(cur_id_q, arb_req_i);
          state_d   = ST_GRANT;
          cur_id_d  = win_id;
          gnt_vld_d = 1'b1;
          gnt_d     = ONE_REQ << win_id;
          cnt_d     = '0;
        end
      end
      ST_GRANT: begin
        if (!req_g) begin
          state_d   = ST_IDLE;
          gnt_vld_d = 1'b0;
          gnt_d     = '0;
        end else if (arb_ack_i) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (last_g) begin
            if (arb_en_i && (|rest_mask)) begin
              win_id   = pick(cur_id_q, rest_mask);
              cur_id_d = win_id;
              gnt_d    = ONE_REQ << win_id;
              cnt_d    = '0;
            end else begin
              state_d   = ST_IDLE;
              gnt_vld_d = 1'b0;
              gnt_d     = '0;
            end
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_vld_d = 1'b0;
        gnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cur_id_q  <= RST_ID;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arb_gnt_vld_o  = gnt_vld_q;
  assign arb_gnt_o      = gnt_q;
  assign arb_gnt_id_o   = cur_id_q;
  assign arb_beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_mcif_rr_arb_seq.sv
// Bench for mcif_rr_arb_seq: directed scenarios plus random traffic against a behavioural model.
module tb_mcif_rr_arb_seq;
  localparam int N     = 5;
  localparam int ID_W  = 3;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            arb_en_i = 1'b0;
  logic [N-1:0]    arb_req_i = '0;
  logic [N-1:0]    arb_last_i = '0;
  logic            arb_ack_i = 1'b0;
  logic            arb_gnt_vld_o;
  logic [N-1:0]    arb_gnt_o;
  logic [ID_W-1:0] arb_gnt_id_o;
  logic [CNT_W-1:0] arb_beat_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state: who owns the channel and how many beats it has moved
  bit m_vld;
  int m_id;
  int m_cnt;

  mcif_rr_arb_seq #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .arb_en_i       (arb_en_i),
    .arb_req_i      (arb_req_i),
    .arb_last_i     (arb_last_i),
    .arb_ack_i      (arb_ack_i),
    .arb_gnt_vld_o  (arb_gnt_vld_o),
    .arb_gnt_o      (arb_gnt_o),
    .arb_gnt_id_o   (arb_gnt_id_o),
    .arb_beat_cnt_o (arb_beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return ptr;
  endfunction

  task automatic model_step();
    logic [N-1:0] others;
    if (!rst_n_i) begin
      m_vld = 1'b0; m_id = N - 1; m_cnt = 0;
    end else if (!m_vld) begin
      if (arb_en_i && arb_req_i != '0) begin
        m_id = rr_pick(m_id, arb_req_i); m_vld = 1'b1; m_cnt = 0;
      end
    end else if (!arb_req_i[m_id]) begin
      m_vld = 1'b0;
    end else if (arb_ack_i) begin
      m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      if (arb_last_i[m_id]) begin
        others = arb_req_i;
        others[m_id] = 1'b0;
        if (arb_en_i && others != '0) begin
          m_id = rr_pick(m_id, others); m_cnt = 0;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
  endtask

  // one clock: advance model with the inputs present at the edge, then compare after it
  task automatic cyc();
    int exp_gnt;
    model_step();
    @(posedge clk_i);
    #1;
    exp_gnt = m_vld ? (1 << m_id) : 0;
    check_eq("gnt_vld", int'(arb_gnt_vld_o), int'(m_vld));
    check_eq("gnt", int'(arb_gnt_o), exp_gnt);
    check_eq("gnt_id", int'(arb_gnt_id_o), m_id);
    check_eq("beat_cnt", int'(arb_beat_cnt_o), m_cnt);
  endtask

  task automatic set_in(input bit en, input logic [N-1:0] req, input logic [N-1:0] last, input bit ack);
    arb_en_i = en; arb_req_i = req; arb_last_i = last; arb_ack_i = ack;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, '0, 1'b0);
    rst_n_i = 1'b0;
    cyc();
    cyc();
    rst_n_i = 1'b1;
    check_eq("rst_vld", int'(arb_gnt_vld_o), 0);
    check_eq("rst_gnt", int'(arb_gnt_o), 0);
    check_eq("rst_id", int'(arb_gnt_id_o), N - 1);
    check_eq("rst_cnt", int'(arb_beat_cnt_o), 0);
  endtask

  initial begin
    int exp_prio[6];
    int exp_wrap[3];
    int exp_cnt[4];
    logic [N-1:0] req_r;
    exp_prio = '{0, 1, 2, 3, 4, 0};
    exp_wrap = '{0, 2, 0};
    exp_cnt  = '{1, 1, 2, 3};

    // reset then everyone requests single-beat: strict rotation from channel 0
    do_reset();
    set_in(1'b1, 5'b11111, 5'b11111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_eq("prio_id", int'(arb_gnt_id_o), exp_prio[i]);
      check_eq("prio_vld", int'(arb_gnt_vld_o), 1);
    end

    // wrap-around from pointer 3
    do_reset();
    set_in(1'b1, 5'b01000, 5'b11111, 1'b1);
    cyc();
    cyc();
    check_eq("wrap_idle", int'(arb_gnt_vld_o), 0);
    set_in(1'b1, 5'b00101, 5'b11111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("wrap_id", int'(arb_gnt_id_o), exp_wrap[i]);
    end

    // multi-beat hold with ack stalls, ch3 waiting
    do_reset();
    set_in(1'b1, 5'b01010, 5'b00000, 1'b0);
    cyc();
    check_eq("hold_first", int'(arb_gnt_id_o), 1);
    for (int i = 0; i < 4; i++) begin
      arb_ack_i = (i != 1);
      cyc();
      check_eq("hold_cnt", int'(arb_beat_cnt_o), exp_cnt[i]);
      check_eq("hold_id", int'(arb_gnt_id_o), 1);
    end
    set_in(1'b1, 5'b01010, 5'b00010, 1'b1);
    cyc();
    check_eq("handover_id", int'(arb_gnt_id_o), 3);
    check_eq("handover_cnt", int'(arb_beat_cnt_o), 0);

    // sole requester: idles one cycle between its transactions
    do_reset();
    set_in(1'b1, 5'b00100, 5'b00100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_eq("sole_vld", int'(arb_gnt_vld_o), (i % 2 == 0) ? 1 : 0);
      check_eq("sole_id", int'(arb_gnt_id_o), 2);
    end

    // withdraw mid-burst, then arb_en gating
    do_reset();
    set_in(1'b1, 5'b10000, 5'b00000, 1'b1);
    cyc();
    cyc();
    set_in(1'b1, 5'b00000, 5'b00000, 1'b1);
    cyc();
    check_eq("wd_vld", int'(arb_gnt_vld_o), 0);
    check_eq("wd_id", int'(arb_gnt_id_o), 4);
    set_in(1'b0, 5'b00011, 5'b00000, 1'b0);
    cyc();
    cyc();
    check_eq("en_block", int'(arb_gnt_vld_o), 0);
    arb_en_i = 1'b1;
    cyc();
    check_eq("en_pick", int'(arb_gnt_id_o), 0);

    // beat counter saturation
    do_reset();
    set_in(1'b1, 5'b00001, 5'b00000, 1'b1);
    for (int i = 0; i < 11; i++) cyc();
    check_eq("sat_cnt", int'(arb_beat_cnt_o), CMAX);

    // reset mid-burst on ch2 beat 3
    do_reset();
    set_in(1'b1, 5'b00100, 5'b00000, 1'b1);
    cyc();
    cyc();
    cyc();
    rst_n_i = 1'b0;
    cyc();
    check_eq("mrst_vld", int'(arb_gnt_vld_o), 0);
    check_eq("mrst_id", int'(arb_gnt_id_o), N - 1);
    check_eq("mrst_cnt", int'(arb_beat_cnt_o), 0);
    rst_n_i = 1'b1;
    set_in(1'b1, 5'b00101, 5'b00000, 1'b1);
    cyc();
    check_eq("mrst_first", int'(arb_gnt_id_o), 0);

    // random traffic against the model
    req_r = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req_r[b] = ~req_r[b];
      end
      arb_req_i  = req_r;
      arb_last_i = N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1));
      arb_ack_i  = ($urandom_range(0, 3) != 0);
      arb_en_i   = ($urandom_range(0, 7) != 0);
      rst_n_i    = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mcif_rr_arb_seq.md
# mcif_rr_arb_seq

Parametrised, registered round-robin arbiter for the MCIF request path. It generalises the fixed 5-way combinational next-ID selector to NUM_REQ channels and adds a grant state machine. A won grant is held for a whole multi-beat transaction, and re-arbitration happens back-to-back on the last beat. It sits between the MCIF client request ports and the shared memory-command channel, and drives the mux select and per-client acknowledge.

## Interface
Parameters:
- NUM_REQ, 5, number of requesting channels (2..16)
- ID_W, 3, width of grant ID; must satisfy 2**ID_W >= NUM_REQ
- CNT_W, 8, width of beat counter (saturating)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- arb_en  input  1  arbitration enable; 0 freezes pointer and blocks new grants
- arb_req  input  NUM_REQ  per-channel request, held high until the channel's last beat is accepted
- arb_last  input  NUM_REQ  per-channel last-beat flag, qualified by arb_req
- arb_ack  input  1  downstream accepts the current beat of the granted channel
- arb_gnt_vld  output  1  a grant is active
- arb_gnt  output  NUM_REQ  one-hot grant; all-zero when arb_gnt_vld=0
- arb_gnt_id  output  ID_W  index of granted or last-granted channel
- arb_beat_cnt  output  CNT_W  beats accepted in the current grant, saturating at all-ones

## Operation
- State machine: IDLE, GRANT.
- Pointer `cur_arb_id`:
  - Register; reset value NUM_REQ-1, so channel 0 has highest priority after reset.
  - Updated only when a grant is issued.
  - The value is presented on arb_gnt_id.
- Selection function `pick(ptr, mask)`:
  - Searches ptr+1, ptr+2, …, wrapping modulo NUM_REQ, ending at ptr itself.
  - Returns the first index with its mask bit set.
- IDLE:
  - If arb_en=1 and |arb_req, register the grant for `pick(cur_arb_id, arb_req)`.
  - Go to GRANT; load the pointer with the winner; clear arb_beat_cnt.
  - Otherwise stay in IDLE.
- GRANT, with g = cur_arb_id:
  - Beat accept: arb_ack=1 and arb_req[g]=1. arb_beat_cnt increments (saturating).
  - Last accept: beat accept with arb_last[g]=1. Re-arbitrate in the same cycle using mask = arb_req with bit g cleared.
    - If arb_en=1 and the mask is non-zero: grant the winner next cycle with no idle bubble, and reset arb_beat_cnt to 0.
    - Else: go to IDLE.
    - The just-finished channel is never re-granted immediately while any other channel requests. It may be re-granted via IDLE on a later cycle.
  - Withdraw: arb_req[g]=0 while in GRANT, without a last accept. Go to IDLE next cycle and keep the pointer. arb_ack is ignored that cycle.
  - arb_en=0 in GRANT does not revoke the current grant; it only blocks the back-to-back handover.
- arb_ack with arb_gnt_vld=0 is ignored.
- arb_req/arb_last bits at index ≥ NUM_REQ do not exist. Unused ID codes never appear on arb_gnt_id.

## Timing
- All outputs are registered. Reset values:
  - arb_gnt_vld=0
  - arb_gnt=0
  - arb_gnt_id=NUM_REQ-1
  - arb_beat_cnt=0
  - state=IDLE
- Reset is synchronous. rst_n=0 in any state, including mid-transaction, returns every output to its reset value at the next edge.
- Request-to-grant latency is 1 cycle: arb_req high at edge N (IDLE) gives arb_gnt_vld=1 after edge N.
- Handover: last accept at edge N gives the new one-hot grant after edge N. Throughput is 1 beat/cycle across transaction boundaries.
- Withdraw gives arb_gnt_vld=0 after the next edge. New arbitration starts one cycle later, from IDLE.
- Single-beat transaction (arb_last=1 on the first beat) is legal. arb_beat_cnt reads 1 only if no handover occurs.
- arb_gnt is always one-hot or zero, and arb_gnt[arb_gnt_id]==arb_gnt_vld.

## Test plan
- Reset/priority: rst_n=0 for 2 cycles, then arb_req=5'b11111 with single-beat transactions and arb_ack=1 continuously → grants 0,1,2,3,4,0 on consecutive cycles; arb_gnt_vld stays 1.
- Wrap-around: NUM_REQ=5, pointer=3, arb_req=5'b00101 → grant 0, then 2, then 0.
- Multi-beat hold: ch1 sends 4 beats with arb_ack toggling 1,0,1,1,1 (last on the 4th accept), ch3 requesting throughout → ch1 holds for 5 cycles with arb_beat_cnt 1,1,2,3; ch3 is granted the cycle after the last accept.
- Sole requester: only ch2 requests, 3 back-to-back transactions → after each last, IDLE for 1 cycle, then ch2 is re-granted.
- Withdraw/arb_en: ch4 drops arb_req mid-burst → arb_gnt_vld=0 next cycle with pointer=4. With arb_en=0 and requests pending → no grant until arb_en=1, then `pick(4, req)` wins.
- Reset mid-burst: rst_n=0 during ch2 beat 3 → next cycle all outputs are at reset values; after release, ch0 wins first if requesting.
